// File: rtl/riscv_crypto_aes_inv_round_pkg.sv
// rtl/riscv_crypto_aes_inv_round_pkg.sv - shared constants and helpers for the AES inverse round unit
//
// Purpose: FSM state encoding, byte/row/column index helpers for the
//          FIPS-197 column-major 128-bit state layout, and GF(2^8) helpers.
// Ports:   none (package).
package riscv_crypto_aes_inv_round_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } aes_state_t;

   // Bit offset of the byte at (row, col): byte index is col*4 + row.
   function automatic logic [6:0] byte_lsb(input logic [1:0] row, input logic [1:0] col);
      return {col, row, 3'b000};
   endfunction

   // Bit offset of 32-bit column col.
   function automatic logic [6:0] col_lsb(input logic [1:0] col);
      return {col, 5'b00000};
   endfunction

   // Source column for InvShiftRows: (col - row) mod 4, wraps naturally in 2 bits.
   function automatic logic [1:0] src_col(input logic [1:0] row, input logic [1:0] col);
      return col - row;
   endfunction

   // Multiply by x modulo 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

endpackage

// File: rtl/riscv_crypto_aes_inv_mixcol.sv
// rtl/riscv_crypto_aes_inv_mixcol.sv - combinational InvMixColumns on one 32-bit column
//
// Purpose: out_r = 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3), built from
//          xtime chains (x2, x4, x8) per input byte.
// Ports:   col_in  [31:0] column, row r in bits [8r+7:8r]
//          col_out [31:0] mixed column, same layout
module riscv_crypto_aes_inv_mixcol
   import riscv_crypto_aes_inv_round_pkg::*;
(
   input  logic [31:0] col_in,
   output logic [31:0] col_out
);

   logic [7:0] m9 [4];
   logic [7:0] mb [4];
   logic [7:0] md [4];
   logic [7:0] me [4];

   for (genvar i = 0; i < 4; i++) begin : g_mul
      logic [7:0] a, x2, x4, x8;
      assign a  = col_in[8*i +: 8];
      assign x2 = xtime(a);
      assign x4 = xtime(x2);
      assign x8 = xtime(x4);
      assign m9[i] = x8 ^ a;
      assign mb[i] = x8 ^ x2 ^ a;
      assign md[i] = x8 ^ x4 ^ a;
      assign me[i] = x8 ^ x4 ^ x2;
   end

   for (genvar r = 0; r < 4; r++) begin : g_out
      assign col_out[8*r +: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
   end

endmodule

// File: rtl/riscv_crypto_aes_inv_sbox.sv
// rtl/riscv_crypto_aes_inv_sbox.sv - combinational inverse AES S-box
//
// Purpose: inverse affine transform followed by multiplicative inverse in
//          GF(2^8) (computed as x^254, which maps 0 to 0 as AES requires).
// Ports:   in_byte  [7:0] input byte
//          out_byte [7:0] InvSubBytes(in_byte)
module riscv_crypto_aes_inv_sbox
   import riscv_crypto_aes_inv_round_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   logic [7:0] b;
   logic [7:0] x2, x3, x12, x15, x60, x63, x252;

   always_comb begin
      // Inverse affine: b_i = s_(i+2) ^ s_(i+5) ^ s_(i+7) ^ 0x05
      b = {in_byte[6:0], in_byte[7]}
        ^ {in_byte[4:0], in_byte[7:5]}
        ^ {in_byte[1:0], in_byte[7:2]}
        ^ 8'h05;
      // Addition chain for b^254
      x2   = gf_mul(b, b);
      x3   = gf_mul(x2, b);
      x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
      x15  = gf_mul(x12, x3);
      x60  = gf_mul(gf_mul(x15, x15), gf_mul(x15, x15));
      x63  = gf_mul(x60, x3);
      x252 = gf_mul(gf_mul(x63, x63), gf_mul(x63, x63));
      out_byte = gf_mul(x252, x2);
   end

endmodule

// File: rtl/riscv_crypto_aes_inv_round.sv
// rtl/riscv_crypto_aes_inv_round.sv - iterative column-serial AES inverse-cipher round
//
// Purpose: one call applies InvShiftRows, InvSubBytes, AddRoundKey and
//          (unless in_last) InvMixColumns, one column per cycle.
// Ports:   g_clk, g_rst (sync active-high), flush (sync abort)
//          in_valid/in_ready, in_state[127:0], in_rkey[127:0], in_last
//          out_valid/out_ready, out_state[127:0]
module riscv_crypto_aes_inv_round
   import riscv_crypto_aes_inv_round_pkg::*;
(
   input  logic         g_clk,
   input  logic         g_rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic [127:0] in_rkey,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state
);

   aes_state_t   fsm;
   logic [1:0]   col;
   logic [127:0] state_q;
   logic [127:0] rkey_q;
   logic         last_q;
   logic [127:0] result_q;

   logic [7:0]   sb_in  [4];
   logic [7:0]   sb_out [4];
   logic [31:0]  sub_col;
   logic [31:0]  mix_col;
   logic [31:0]  new_col;

   // InvShiftRows folded into the gather: row r of column c comes from column c-r.
   for (genvar r = 0; r < 4; r++) begin : g_row
      assign sb_in[r] = state_q[byte_lsb(2'(r), src_col(2'(r), col)) +: 8];
      riscv_crypto_aes_inv_sbox u_sbox (
         .in_byte  (sb_in[r]),
         .out_byte (sb_out[r])
      );
   end

   assign sub_col = {sb_out[3], sb_out[2], sb_out[1], sb_out[0]} ^ rkey_q[col_lsb(col) +: 32];

   riscv_crypto_aes_inv_mixcol u_mixcol (
      .col_in  (sub_col),
      .col_out (mix_col)
   );

   assign new_col = last_q ? sub_col : mix_col;

   always_ff @(posedge g_clk) begin
      if (g_rst) begin
         fsm      <= ST_IDLE;
         col      <= 2'd0;
         state_q  <= '0;
         rkey_q   <= '0;
         last_q   <= 1'b0;
         result_q <= '0;
      end else if (flush) begin
         fsm <= ST_IDLE;
         col <= 2'd0;
      end else begin
         case (fsm)
            ST_IDLE: begin
               if (in_valid) begin
                  state_q <= in_state;
                  rkey_q  <= in_rkey;
                  last_q  <= in_last;
                  col     <= 2'd0;
                  fsm     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               result_q[col_lsb(col) +: 32] <= new_col;
               col <= col + 2'd1;
               if (col == 2'd3) fsm <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) fsm <= ST_IDLE;
            end
            default: fsm <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (fsm == ST_IDLE);
   assign out_valid = (fsm == ST_DONE);
   assign out_state = result_q;

endmodule

// File: tb/tb_riscv_crypto_aes_inv_round.sv
// tb/tb_riscv_crypto_aes_inv_round.sv - self-checking bench for the AES inverse round unit
module tb_riscv_crypto_aes_inv_round;

   logic         g_clk = 1'b0;
   logic         g_rst = 1'b1;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_state = '0;
   logic [127:0] in_rkey = '0;
   logic         in_last = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] out_state;

   int total = 0;
   int bad = 0;

   logic [7:0] inv_sb [256];

   always #5 g_clk = ~g_clk;

   riscv_crypto_aes_inv_round dut (
      .g_clk     (g_clk),
      .g_rst     (g_rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .in_rkey   (in_rkey),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state)
   );

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] x, input int k);
      return (x << k) | (x >> (8 - k));
   endfunction

   // Forward S-box from brute-force inverse + affine map, then invert the table.
   task automatic build_tables();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] iv;
         logic [7:0] f;
         iv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gm(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
         f = iv ^ rl(iv, 1) ^ rl(iv, 2) ^ rl(iv, 3) ^ rl(iv, 4) ^ 8'h63;
         inv_sb[f] = 8'(x);
      end
   endtask

   function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k, input logic l);
      logic [7:0] t [4][4];
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            t[r][c] = inv_sb[s[8*(4*((c-r+4)%4)+r) +: 8]] ^ k[8*(4*c+r) +: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(4*c+r) +: 8] = l ? t[r][c]
               : gm(8'h0e, t[r][c]) ^ gm(8'h0b, t[(r+1)%4][c])
               ^ gm(8'h0d, t[(r+2)%4][c]) ^ gm(8'h09, t[(r+3)%4][c]);
      return o;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic accept(input logic [127:0] s, input logic [127:0] k, input logic l);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin @(posedge g_clk); #1; n++; end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL accept_ready got=%b want=1", in_ready); end
      in_state = s; in_rkey = k; in_last = l; in_valid = 1'b1;
      @(posedge g_clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 50) begin @(posedge g_clk); #1; lat++; end
   endtask

   task automatic run_req(input logic [127:0] s, input logic [127:0] k, input logic l,
                          input logic scramble, output logic [127:0] res, output int lat,
                          output logic idle);
      accept(s, k, l);
      if (scramble) begin in_state = rnd128(); in_rkey = rnd128(); in_last = ~l; end
      wait_valid(lat);
      res = out_state;
      out_ready = 1'b1;
      @(posedge g_clk); #1;
      out_ready = 1'b0;
      idle = in_ready & ~out_valid;
   endtask

   task automatic test_reset();
      g_rst = 1'b1;
      repeat (2) @(posedge g_clk);
      #1 g_rst = 1'b0;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (out_state !== 128'h0) begin bad++; $display("FAIL reset_out_state got=%h want=0", out_state); end
   endtask

   task automatic test_known();
      logic [127:0] s [5];
      logic [127:0] k [5];
      logic         l [5];
      logic [127:0] want [5];
      logic [127:0] res;
      int lat;
      logic idle;
      s[0] = '0;                 k[0] = '0;                 l[0] = 1'b1; want[0] = {16{8'h52}};
      s[1] = '0;                 k[1] = '0;                 l[1] = 1'b0; want[1] = {16{8'h52}};
      s[2] = {16{8'h63}};        k[2] = '0;                 l[2] = 1'b1; want[2] = '0;
      s[3] = '0;                 k[3] = {16{8'hff}};        l[3] = 1'b1; want[3] = {16{8'had}};
      s[4] = {{12{8'h63}}, 32'h0}; k[4] = '0;               l[4] = 1'b1; want[4] = ref_round(s[4], k[4], l[4]);
      for (int i = 0; i < 5; i++) begin
         run_req(s[i], k[i], l[i], 1'b0, res, lat, idle);
         total++; if (res !== want[i]) begin bad++; $display("FAIL known_%0d got=%h want=%h", i, res, want[i]); end
         total++; if (lat !== 4) begin bad++; $display("FAIL known_lat_%0d got=%0d want=4", i, lat); end
         total++; if (idle !== 1'b1) begin bad++; $display("FAIL known_idle_%0d got=%b want=1", i, idle); end
      end
      // InvShiftRows mapping: column 0 is 0x52 in row 0 only
      total++; if (want[4][31:0] !== 32'h0000_0052) begin bad++; $display("FAIL shiftrows_ref got=%h want=00000052", want[4][31:0]); end
      total++; if (res[31:0] !== 32'h0000_0052) begin bad++; $display("FAIL shiftrows_col0 got=%h want=00000052", res[31:0]); end
   endtask

   task automatic test_random();
      logic [127:0] s, k, res, want;
      logic l, idle;
      int lat;
      for (int i = 0; i < 24; i++) begin
         s = rnd128(); k = rnd128(); l = 1'($urandom_range(0, 1));
         want = ref_round(s, k, l);
         run_req(s, k, l, 1'b1, res, lat, idle);
         total++; if (res !== want) begin bad++; $display("FAIL random_%0d last=%b got=%h want=%h", i, l, res, want); end
         total++; if (lat !== 4) begin bad++; $display("FAIL random_lat_%0d got=%0d want=4", i, lat); end
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] s, k, want;
      int lat;
      int errs;
      s = rnd128(); k = rnd128();
      want = ref_round(s, k, 1'b0);
      accept(s, k, 1'b0);
      wait_valid(lat);
      errs = 0;
      for (int i = 0; i < 10; i++) begin
         if (out_state !== want || in_ready !== 1'b0 || out_valid !== 1'b1) errs++;
         @(posedge g_clk); #1;
      end
      total++; if (errs !== 0) begin bad++; $display("FAIL backpressure_hold got=%0d bad_cycles want=0", errs); end
      total++; if (out_state !== want) begin bad++; $display("FAIL backpressure_data got=%h want=%h", out_state, want); end
      out_ready = 1'b1;
      @(posedge g_clk); #1;
      out_ready = 1'b0;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL backpressure_release got=%b%b want=10", in_ready, out_valid); end
   endtask

   task automatic test_flush();
      logic [127:0] s, k, res, want;
      logic idle;
      int lat;
      int errs;
      accept(rnd128(), rnd128(), 1'b0);
      repeat (2) @(posedge g_clk);
      #1 flush = 1'b1;
      @(posedge g_clk); #1;
      flush = 1'b0;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_idle got=%b%b want=10", in_ready, out_valid); end
      errs = 0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid !== 1'b0) errs++;
         @(posedge g_clk); #1;
      end
      total++; if (errs !== 0) begin bad++; $display("FAIL flush_no_valid got=%0d want=0", errs); end
      s = rnd128(); k = rnd128(); want = ref_round(s, k, 1'b1);
      run_req(s, k, 1'b1, 1'b0, res, lat, idle);
      total++; if (res !== want) begin bad++; $display("FAIL flush_next got=%h want=%h", res, want); end
   endtask

   task automatic test_reset_done();
      logic [127:0] s, k, res, want;
      logic idle;
      int lat;
      accept(rnd128(), rnd128(), 1'b0);
      wait_valid(lat);
      g_rst = 1'b1;
      @(posedge g_clk); #1;
      g_rst = 1'b0;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL rst_done_idle got=%b%b want=10", in_ready, out_valid); end
      total++; if (out_state !== 128'h0) begin bad++; $display("FAIL rst_done_clear got=%h want=0", out_state); end
      s = rnd128(); k = rnd128(); want = ref_round(s, k, 1'b0);
      run_req(s, k, 1'b0, 1'b0, res, lat, idle);
      total++; if (res !== want) begin bad++; $display("FAIL rst_done_next got=%h want=%h", res, want); end
   endtask

   task automatic test_back_to_back();
      logic [127:0] s, k, want;
      int n;
      s = rnd128(); k = rnd128(); want = ref_round(s, k, 1'b1);
      out_ready = 1'b1;
      accept(s, k, 1'b1);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge g_clk); #1; n++;
         if (out_valid) begin
            total++; if (out_state !== want) begin bad++; $display("FAIL b2b_data got=%h want=%h", out_state, want); end
         end
      end
      total++; if (n !== 5) begin bad++; $display("FAIL b2b_idle_delay got=%0d want=5", n); end
      @(posedge g_clk); #1;
      in_valid = 1'b0;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_reaccept got=%b want=0", in_ready); end
      repeat (6) @(posedge g_clk);
      #1 out_ready = 1'b0;
   endtask

   initial begin
      build_tables();
      test_reset();
      test_known();
      test_random();
      test_backpressure();
      test_flush();
      test_reset_done();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
